// File: rtl/sipo_sync.sv
// sipo_sync: sclk-domain receiver for the two-wire scl/sda link.
// Oversamples scl/sda, detects START/STOP/RISE, shifts WIDTH bits MSB-first,
// and presents the word with a one-cycle d_valid strobe or an err pulse.
module sipo_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             scl,
  input  logic             sda,
  output logic [WIDTH-1:0] data,
  output logic             d_valid,
  output logic             rx,
  output logic             err,
  output logic [2:0]       state
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    STOPW = 3'd2,
    DONE  = 3'd3
  } state_e;

  logic s1_scl_q, s_scl_q, p_scl_q;
  logic s1_sda_q, s_sda_q, p_sda_q;

  logic ev_start, ev_stop, ev_rise, ev_fall;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] data_q;
  logic             dv_q;
  logic             err_q;
  logic             rx_q;
  logic             arm_q;

  // Two-flop synchronizers plus one history flop; idle bus reads high.
  always_ff @(posedge sclk) begin
    if (!rst) begin
      s1_scl_q <= 1'b1;
      s_scl_q  <= 1'b1;
      p_scl_q  <= 1'b1;
      s1_sda_q <= 1'b1;
      s_sda_q  <= 1'b1;
      p_sda_q  <= 1'b1;
    end else begin
      s1_scl_q <= scl;
      s_scl_q  <= s1_scl_q;
      p_scl_q  <= s_scl_q;
      s1_sda_q <= sda;
      s_sda_q  <= s1_sda_q;
      p_sda_q  <= s_sda_q;
    end
  end

  // Bus events from synchronized current and previous samples.
  always_comb begin
    ev_start = p_scl_q & s_scl_q &  p_sda_q & ~s_sda_q;
    ev_stop  = p_scl_q & s_scl_q & ~p_sda_q &  s_sda_q;
    ev_rise  = ~p_scl_q & s_scl_q;
    ev_fall  = p_scl_q & ~s_scl_q;
  end

  // Frame FSM with registered outputs.
  // In STOPW the scl rise that precedes STOP (sda held low) is only armed;
  // it becomes an extra-bit error if scl falls again instead of STOP following.
  // A rise with sda high can never lead to STOP, so it errors immediately.
  always_ff @(posedge sclk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      rx_q    <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      dv_q  <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ev_start) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            rx_q    <= 1'b1;
          end
        end
        SHIFT: begin
          if (ev_start) begin
            err_q <= 1'b1;
            cnt_q <= '0;
          end else if (ev_stop) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
            rx_q    <= 1'b0;
          end else if (ev_rise) begin
            sh_q  <= {sh_q[WIDTH-2:0], s_sda_q};
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              state_q <= STOPW;
              arm_q   <= 1'b0;
            end
          end
        end
        STOPW: begin
          if (ev_stop) begin
            state_q <= DONE;
            rx_q    <= 1'b0;
            arm_q   <= 1'b0;
          end else if (ev_start) begin
            err_q   <= 1'b1;
            state_q <= SHIFT;
            cnt_q   <= '0;
            arm_q   <= 1'b0;
          end else if (ev_rise) begin
            if (s_sda_q) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
              rx_q    <= 1'b0;
            end else begin
              arm_q <= 1'b1;
            end
          end else if (ev_fall && arm_q) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
            rx_q    <= 1'b0;
            arm_q   <= 1'b0;
          end
        end
        DONE: begin
          data_q  <= sh_q;
          dv_q    <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          rx_q    <= 1'b0;
          arm_q   <= 1'b0;
        end
      endcase
    end
  end

  assign data    = data_q;
  assign d_valid = dv_q;
  assign err     = err_q;
  assign rx      = rx_q;
  assign state   = state_q;

endmodule

// File: tb/tb_sipo_sync.sv
// tb_sipo_sync: directed frames on scl/sda with hand-computed expectations.
module tb_sipo_sync;

  logic       sclk = 1'b0;
  logic       rst  = 1'b0;
  logic       scl  = 1'b1;
  logic       sda  = 1'b1;
  logic [3:0] data;
  logic       d_valid;
  logic       rx;
  logic       err;
  logic [2:0] state;

  int unsigned n_err = 0;
  int unsigned n_chk = 0;

  int unsigned dv_cnt   = 0;
  int unsigned err_cnt  = 0;
  int unsigned both_cnt = 0;
  int unsigned glitch   = 0;
  logic [3:0]  prev_data = '0;

  int unsigned dv0, er0, gl0;

  sipo_sync #(.WIDTH(4)) dut (
    .sclk    (sclk),
    .rst     (rst),
    .scl     (scl),
    .sda     (sda),
    .data    (data),
    .d_valid (d_valid),
    .rx      (rx),
    .err     (err),
    .state   (state)
  );

  always #100 sclk = ~sclk;

  // Event counters sampled away from the active edge.
  always @(negedge sclk) begin
    if (d_valid) dv_cnt++;
    if (err) err_cnt++;
    if (err && d_valid) both_cnt++;
    if (rst && (data !== prev_data) && !d_valid) glitch++;
    prev_data = data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic start_c();
    sda = 1'b0; cyc(5);
    scl = 1'b0; cyc(2);
  endtask

  task automatic restart_c();
    sda = 1'b1; cyc(3);
    scl = 1'b1; cyc(5);
    sda = 1'b0; cyc(5);
    scl = 1'b0; cyc(2);
  endtask

  task automatic bitx(input logic b);
    sda = b;    cyc(3);
    scl = 1'b1; cyc(5);
    scl = 1'b0; cyc(2);
  endtask

  // STOP, then sample d_valid on the 2nd..5th edges counted from the
  // edge that first samples sda high; lat[i] holds edge i+2.
  task automatic stop_c(input string tag, input logic [3:0] exp_lat);
    logic [3:0] lat;
    sda = 1'b0; cyc(3);
    scl = 1'b1; cyc(5);
    sda = 1'b1;
    @(posedge sclk);
    for (int i = 0; i < 4; i++) begin
      @(posedge sclk); #1;
      lat[i] = d_valid;
    end
    check(tag, {28'd0, lat}, {28'd0, exp_lat});
    cyc(5);
  endtask

  task automatic frame(input logic [3:0] w, input string tag);
    logic [3:0] v;
    v = w;
    start_c();
    for (int i = 3; i >= 0; i--) bitx(v[i]);
    stop_c(tag, 4'b0100);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    cyc(2);
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_data", {28'd0, data}, 32'd0);
    check("rst_dv", {31'd0, d_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rx", {31'd0, rx}, 32'd0);
    rst = 1'b1;
    cyc(5);
    gl0 = glitch;

    // Single frame 1101 with latency and rx checks.
    dv0 = dv_cnt; er0 = err_cnt;
    start_c();
    check("f1_rx_start", {31'd0, rx}, 32'd1);
    check("f1_state_shift", {29'd0, state}, 32'd1);
    bitx(1'b1); bitx(1'b1); bitx(1'b0); bitx(1'b1);
    check("f1_rx_bits", {31'd0, rx}, 32'd1);
    check("f1_state_stopw", {29'd0, state}, 32'd2);
    stop_c("f1_latency", 4'b0100);
    check("f1_data", {28'd0, data}, 32'hD);
    check("f1_dv_cnt", dv_cnt - dv0, 32'd1);
    check("f1_err_cnt", err_cnt - er0, 32'd0);
    check("f1_rx_end", {31'd0, rx}, 32'd0);

    // Back-to-back frames separated by idle.
    cyc(50);
    dv0 = dv_cnt; er0 = err_cnt;
    frame(4'h4, "f2a_latency");
    check("f2a_data", {28'd0, data}, 32'h4);
    cyc(50);
    check("f2_hold", {28'd0, data}, 32'h4);
    frame(4'hB, "f2b_latency");
    check("f2b_data", {28'd0, data}, 32'hB);
    check("f2_dv_cnt", dv_cnt - dv0, 32'd2);
    check("f2_err_cnt", err_cnt - er0, 32'd0);

    // Short frame: two bits then STOP.
    cyc(10);
    dv0 = dv_cnt; er0 = err_cnt;
    start_c();
    bitx(1'b1); bitx(1'b0);
    stop_c("f3_no_dv", 4'b0000);
    check("f3_err_cnt", err_cnt - er0, 32'd1);
    check("f3_dv_cnt", dv_cnt - dv0, 32'd0);
    check("f3_data", {28'd0, data}, 32'hB);
    check("f3_state", {29'd0, state}, 32'd0);

    // Restart after two bits, then a full 0110 frame.
    cyc(10);
    dv0 = dv_cnt; er0 = err_cnt;
    start_c();
    bitx(1'b1); bitx(1'b1);
    restart_c();
    check("f4_err_restart", err_cnt - er0, 32'd1);
    check("f4_state_restart", {29'd0, state}, 32'd1);
    bitx(1'b0); bitx(1'b1); bitx(1'b1); bitx(1'b0);
    stop_c("f4_latency", 4'b0100);
    check("f4_data", {28'd0, data}, 32'h6);
    check("f4_dv_cnt", dv_cnt - dv0, 32'd1);
    check("f4_err_cnt", err_cnt - er0, 32'd1);
    check("data_stable", glitch - gl0, 32'd0);

    // Fifth scl rise with sda high is an extra bit.
    cyc(10);
    dv0 = dv_cnt; er0 = err_cnt;
    start_c();
    bitx(1'b1); bitx(1'b0); bitx(1'b1); bitx(1'b1);
    sda = 1'b1; cyc(3);
    scl = 1'b1; cyc(5);
    check("f5_err_cnt", err_cnt - er0, 32'd1);
    check("f5_state", {29'd0, state}, 32'd0);
    check("f5_rx", {31'd0, rx}, 32'd0);
    scl = 1'b0; cyc(3);
    scl = 1'b1; cyc(5);
    check("f5_dv_cnt", dv_cnt - dv0, 32'd0);
    check("f5_err_after", err_cnt - er0, 32'd1);

    // Reset during bit 2, then a clean 1001 frame.
    cyc(10);
    dv0 = dv_cnt; er0 = err_cnt;
    start_c();
    bitx(1'b1);
    sda = 1'b0; cyc(3);
    scl = 1'b1; cyc(2);
    rst = 1'b0;
    @(posedge sclk); #1;
    check("r_state", {29'd0, state}, 32'd0);
    check("r_data", {28'd0, data}, 32'd0);
    check("r_dv", {31'd0, d_valid}, 32'd0);
    check("r_err", {31'd0, err}, 32'd0);
    check("r_rx", {31'd0, rx}, 32'd0);
    sda = 1'b1; cyc(3);
    rst = 1'b1; cyc(5);
    check("r_err_cnt", err_cnt - er0, 32'd0);
    check("r_state_idle", {29'd0, state}, 32'd0);
    frame(4'h9, "f6_latency");
    check("f6_data", {28'd0, data}, 32'h9);
    check("f6_dv_cnt", dv_cnt - dv0, 32'd1);
    check("f6_err_cnt", err_cnt - er0, 32'd0);

    check("err_dv_overlap", both_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sipo_sync.md
Name: sipo_sync

Overview:
- Single-clock receiver for the two-wire scl/sda serial link driven by `piso`.
- Oversamples scl and sda on the system clock `sclk`.
- Decodes START and STOP conditions, shifts in WIDTH data bits MSB-first, and presents the parallel word with a one-cycle valid strobe.
- Replaces the edge-clocked receiver wherever the consumer lives in the `sclk` domain. Also reports frame errors for aborted or malformed frames.

Parameters:
- WIDTH, 4, data bits per frame (2..16).

Ports:
- sclk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-low.
- scl  input  1  serial clock from transmitter; asynchronous to sclk.
- sda  input  1  serial data from transmitter; asynchronous to sclk.
- data  output  WIDTH  last correctly received word.
- d_valid  output  1  one-cycle pulse when data updates.
- rx  output  1  high while a frame is in progress (START seen, not yet finished).
- err  output  1  one-cycle pulse on a frame error.
- state  output  3  current FSM state encoding, for debug.

Behaviour:
- Synchronizer:
  - scl and sda each pass through 2 flops (s_*), plus one history flop (p_*).
  - All synchronizer and history flops reset to 1 (idle bus is high).
- Events, evaluated each cycle from synchronized values:
  - START: p_scl=1 and s_scl=1 and p_sda=1 and s_sda=0.
  - STOP: p_scl=1 and s_scl=1 and p_sda=0 and s_sda=1.
  - RISE: p_scl=0 and s_scl=1; samples s_sda of the same cycle.
  - An sda change coincident with an scl change is never START or STOP.
- Reset (rst=0 at a clock edge):
  - state=IDLE, data=0, d_valid=0, err=0, rx=0, bit counter=0, shift register=0.
  - Reset mid-frame discards the partial frame with no err pulse.
- FSM encoding: IDLE=0, SHIFT=1, STOPW=2, DONE=3.
  - IDLE: START -> SHIFT; clear counter. RISE and STOP are ignored.
  - SHIFT: on RISE, shift s_sda into the LSB of the shift register and increment the counter. When the counter reaches WIDTH -> STOPW.
  - SHIFT, START: restart. err pulse, counter cleared, stay SHIFT.
  - SHIFT, STOP before WIDTH bits: err pulse -> IDLE; data unchanged.
  - STOPW, STOP: -> DONE.
  - STOPW, RISE (extra bit): err pulse -> IDLE.
  - STOPW, START: err pulse -> SHIFT, counter cleared.
  - DONE: lasts one cycle. data <= shift register, d_valid=1 -> IDLE.
- rx=1 in SHIFT and STOPW, else 0.
- Latency: d_valid rises on the 4th sclk edge after the first edge that samples sda high during STOP (2 sync + detect + DONE register).
- data holds its value until the next good frame; never updated on error.
- err and d_valid are never high in the same cycle.
- Timing requirement: scl high and low phases, and sda setup/hold around each condition, must each be >= 3 sclk periods. Shorter pulses are not guaranteed to be seen.

Test Plan:
- Frame, sclk period 200 ns, scl phases 1000 ns:
  - Stimulus: rst low 2 cycles, then START, bits 1,1,0,1, STOP.
  - Required: data=4'b1101, single d_valid pulse 4 edges after the STOP sample, err=0, rx high from START to STOP.
- Back-to-back frames:
  - Stimulus: 4'b0100 then 4'b1011, separated by 10 us idle.
  - Required: two d_valid pulses with data 4'h4 then 4'hB; data stable between pulses.
- Short frame:
  - Stimulus: START, bits 1,0, STOP.
  - Required: err pulse, no d_valid, data keeps previous value 4'hB, state returns to 0.
- Restart mid-frame:
  - Stimulus: START, bits 1,1, START, bits 0,1,1,0, STOP.
  - Required: one err pulse at the second START, then d_valid with data=4'b0110.
- Extra bit and reset:
  - Stimulus: 5 scl rising edges after START, before STOP.
  - Required: err pulse on the 5th edge, IDLE.
  - Stimulus: separately, rst=0 during bit 2 of a frame.
  - Required: all outputs 0 on the next edge, no err, then the following clean frame 4'b1001 is received correctly.
